// File: rtl/scariv_fpu_done_merge.sv
// Merges the FPU mv and fpnew done reports into one ROB done port, fp before mv on a same-cycle collision.
// Latency: 2 cycles through the FIFO; 1 cycle when SCARIV_FPU_DONE_MERGE_BYPASS_EN lets a lone report skip an empty FIFO.
// Backpressure: o_stall is raised from the registered count once fewer than 2*SKID entries are free.
//
// Optional feature macro: SCARIV_FPU_DONE_MERGE_BYPASS_EN (empty-FIFO bypass into the output register).
// Ports:
//   i_clk / i_reset_n                   clock, asynchronous active-low reset
//   i_mv_*                              mv done report (no fflags; reported fflags forced to 0)
//   i_fp_*                              fpnew done report including accrued fflags
//   i_flush_valid / i_flush_cmt_id      branch mispredict; kills everything younger than the branch
//   o_stall                             stall request to the FPU issue unit
//   o_done_*                            merged, registered done report toward the ROB
module scariv_fpu_done_merge #(
    parameter int DEPTH    = 4,
    parameter int CMT_ID_W = 7,
    parameter int GRP_ID_W = 4,
    parameter int SKID     = 2
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_mv_valid,
    input  logic [CMT_ID_W-1:0] i_mv_cmt_id,
    input  logic [GRP_ID_W-1:0] i_mv_grp_id,
    input  logic                i_mv_except_valid,
    input  logic [3:0]          i_mv_except_type,
    input  logic                i_fp_valid,
    input  logic [CMT_ID_W-1:0] i_fp_cmt_id,
    input  logic [GRP_ID_W-1:0] i_fp_grp_id,
    input  logic                i_fp_except_valid,
    input  logic [3:0]          i_fp_except_type,
    input  logic                i_fp_fflags_valid,
    input  logic [4:0]          i_fp_fflags,
    input  logic                i_flush_valid,
    input  logic [CMT_ID_W-1:0] i_flush_cmt_id,
    output logic                o_stall,
    output logic                o_done_valid,
    output logic [CMT_ID_W-1:0] o_done_cmt_id,
    output logic [GRP_ID_W-1:0] o_done_grp_id,
    output logic                o_done_except_valid,
    output logic [3:0]          o_done_except_type,
    output logic                o_done_fflags_valid,
    output logic [4:0]          o_done_fflags
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = CMT_ID_W - 1;

    typedef struct packed {
        logic                live;
        logic [CMT_ID_W-1:0] cmt_id;
        logic [GRP_ID_W-1:0] grp_id;
        logic                except_valid;
        logic [3:0]          except_type;
        logic                fflags_valid;
        logic [4:0]          fflags;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           out_q, out_next, fp_ent, mv_ent, head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, mv_slot;
    logic [CNT_W-1:0] count, free_cnt, n_wr;
    logic             empty, pop, head_ok;
    logic             fp_ok, mv_ok, byp_fp, byp_mv, wr_fp, wr_mv, acc_fp, acc_mv;

    // ROB order: same wrap bit compares indices directly; across a wrap the
    // smaller index is the younger one. Equal ids are not younger.
    function automatic logic is_younger(input logic [CMT_ID_W-1:0] e,
                                        input logic [CMT_ID_W-1:0] f);
        if (e[CMT_ID_W-1] == f[CMT_ID_W-1]) begin
            return e[IDX_W-1:0] > f[IDX_W-1:0];
        end
        return e[IDX_W-1:0] < f[IDX_W-1:0];
    endfunction

    always_comb begin
        fp_ent              = '0;
        fp_ent.live         = 1'b1;
        fp_ent.cmt_id       = i_fp_cmt_id;
        fp_ent.grp_id       = i_fp_grp_id;
        fp_ent.except_valid = i_fp_except_valid;
        fp_ent.except_type  = i_fp_except_type;
        fp_ent.fflags_valid = i_fp_fflags_valid;
        fp_ent.fflags       = i_fp_fflags;
        mv_ent              = '0;
        mv_ent.live         = 1'b1;
        mv_ent.cmt_id       = i_mv_cmt_id;
        mv_ent.grp_id       = i_mv_grp_id;
        mv_ent.except_valid = i_mv_except_valid;
        mv_ent.except_type  = i_mv_except_type;
    end

    // Reports younger than a same-cycle flush never take a slot.
    assign fp_ok = i_fp_valid & ~(i_flush_valid & is_younger(i_fp_cmt_id, i_flush_cmt_id));
    assign mv_ok = i_mv_valid & ~(i_flush_valid & is_younger(i_mv_cmt_id, i_flush_cmt_id));

    assign empty   = (count == '0);
    assign pop     = ~empty;
    assign head    = mem[rd_ptr];
    assign head_ok = head.live & ~(i_flush_valid & is_younger(head.cmt_id, i_flush_cmt_id));

`ifdef SCARIV_FPU_DONE_MERGE_BYPASS_EN
    assign byp_fp = empty & fp_ok;
    assign byp_mv = empty & ~fp_ok & mv_ok;
`else
    assign byp_fp = 1'b0;
    assign byp_mv = 1'b0;
`endif

    assign wr_fp    = fp_ok & ~byp_fp;
    assign wr_mv    = mv_ok & ~byp_mv;
    // Free slots come from the registered count only; a same-cycle pop does
    // not make room for a write.
    assign free_cnt = CNT_W'(DEPTH) - count;
    assign acc_fp   = wr_fp & (free_cnt != '0);
    assign acc_mv   = wr_mv & (free_cnt > CNT_W'(acc_fp));
    assign n_wr     = CNT_W'(acc_fp) + CNT_W'(acc_mv);
    assign mv_slot  = wr_ptr + PTR_W'(acc_fp);

    assign o_stall  = int'(free_cnt) < (2 * SKID);

    // The output register holds a report for exactly one cycle. A dead or
    // just-flushed head still pops but leaves the register empty.
    always_comb begin
        out_next = '0;
        if (pop) begin
            if (head_ok) begin
                out_next = head;
            end
        end else if (byp_fp) begin
            out_next = fp_ent;
        end else if (byp_mv) begin
            out_next = mv_ent;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            out_q  <= '0;
        end else begin
            // Killed entries keep their slot until popped so ordering and
            // count stay simple.
            if (i_flush_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (is_younger(mem[i].cmt_id, i_flush_cmt_id)) begin
                        mem[i].live <= 1'b0;
                    end
                end
            end
            if (pop) begin
                mem[rd_ptr].live <= 1'b0;
            end
            if (acc_fp) begin
                mem[wr_ptr] <= fp_ent;
            end
            if (acc_mv) begin
                mem[mv_slot] <= mv_ent;
            end
            wr_ptr <= wr_ptr + n_wr[PTR_W-1:0];
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + n_wr - CNT_W'(pop);
            out_q  <= out_next;
        end
    end

    always @(posedge i_clk) begin
        if (i_reset_n && ((wr_fp && !acc_fp) || (wr_mv && !acc_mv))) begin
            $error("scariv_fpu_done_merge: done report dropped, no free FIFO entry");
        end
    end

    assign o_done_valid        = out_q.live;
    assign o_done_cmt_id       = out_q.cmt_id;
    assign o_done_grp_id       = out_q.grp_id;
    assign o_done_except_valid = out_q.except_valid;
    assign o_done_except_type  = out_q.except_type;
    assign o_done_fflags_valid = out_q.fflags_valid;
    assign o_done_fflags       = out_q.fflags;

endmodule

// File: tb/tb_scariv_fpu_done_merge.sv
// Self-checking bench for scariv_fpu_done_merge: directed cases plus random traffic against a queue model.
// Latency: inputs driven on a falling edge, outputs sampled on the next falling edges.
// Backpressure: stimulus never offers more reports than the model's free slots.
module tb_scariv_fpu_done_merge;
    localparam int DEPTH = 4;
    localparam int SKID  = 2;
`ifdef SCARIV_FPU_DONE_MERGE_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic       v;
        logic [6:0] id;
        logic [3:0] grp;
        logic       ev;
        logic [3:0] et;
        logic       fv;
        logic [4:0] ff;
    } rep_t;

    localparam rep_t IDLE = '0;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    rep_t       fp_in = '0;
    rep_t       mv_in = '0;
    logic       fl_v  = 1'b0;
    logic [6:0] fl_id = '0;

    logic       o_stall, o_done_valid, o_done_except_valid, o_done_fflags_valid;
    logic [6:0] o_done_cmt_id;
    logic [3:0] o_done_grp_id, o_done_except_type;
    logic [4:0] o_done_fflags;

    always #5 clk = ~clk;

    scariv_fpu_done_merge #(.DEPTH(DEPTH), .CMT_ID_W(7), .GRP_ID_W(4), .SKID(SKID)) dut (
        .i_clk              (clk),
        .i_reset_n          (rst_n),
        .i_mv_valid         (mv_in.v),
        .i_mv_cmt_id        (mv_in.id),
        .i_mv_grp_id        (mv_in.grp),
        .i_mv_except_valid  (mv_in.ev),
        .i_mv_except_type   (mv_in.et),
        .i_fp_valid         (fp_in.v),
        .i_fp_cmt_id        (fp_in.id),
        .i_fp_grp_id        (fp_in.grp),
        .i_fp_except_valid  (fp_in.ev),
        .i_fp_except_type   (fp_in.et),
        .i_fp_fflags_valid  (fp_in.fv),
        .i_fp_fflags        (fp_in.ff),
        .i_flush_valid      (fl_v),
        .i_flush_cmt_id     (fl_id),
        .o_stall            (o_stall),
        .o_done_valid       (o_done_valid),
        .o_done_cmt_id      (o_done_cmt_id),
        .o_done_grp_id      (o_done_grp_id),
        .o_done_except_valid(o_done_except_valid),
        .o_done_except_type (o_done_except_type),
        .o_done_fflags_valid(o_done_fflags_valid),
        .o_done_fflags      (o_done_fflags)
    );

    // Model state: queue of accepted reports (v = still alive) and the
    // expected outputs after the next rising edge.
    rep_t       q[$];
    logic       exp_v     = 1'b0;
    rep_t       exp_r     = '0;
    logic       exp_stall = 1'b0;
    int         nvec      = 0;
    int         nfail     = 0;
    logic [6:0] seen[$];
    logic       last_v, last_fv, last_stall;
    logic [6:0] last_id;
    logic [4:0] last_ff;

    function automatic bit younger(input logic [6:0] e, input logic [6:0] f);
        if (e[6] == f[6]) return e[5:0] > f[5:0];
        return e[5:0] < f[5:0];
    endfunction

    function automatic rep_t mk(input logic [6:0] id, input logic [3:0] grp, input logic ev,
                                input logic [3:0] et, input logic fv, input logic [4:0] ff);
        return {1'b1, id, grp, ev, et, fv, ff};
    endfunction

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic check();
        logic [21:0] got, want;
        nvec++;
        if (o_done_valid !== exp_v) begin
            nfail++;
            $display("FAIL done_valid: got %b want %b at %0t", o_done_valid, exp_v, $time);
        end
        nvec++;
        if (o_stall !== exp_stall) begin
            nfail++;
            $display("FAIL stall: got %b want %b at %0t", o_stall, exp_stall, $time);
        end
        if (exp_v) begin
            nvec++;
            got  = {o_done_cmt_id, o_done_grp_id, o_done_except_valid, o_done_except_type,
                    o_done_fflags_valid, o_done_fflags};
            want = {exp_r.id, exp_r.grp, exp_r.ev, exp_r.et, exp_r.fv, exp_r.ff};
            if (got !== want) begin
                nfail++;
                $display("FAIL done_fields: got %h want %h at %0t", got, want, $time);
            end
        end
    endtask

    // Reference behaviour for one rising edge: kill younger entries, pop the
    // oldest, accept surviving inputs in fp-then-mv order.
    task automatic model(input rep_t fp, input rep_t mv, input logic flv, input logic [6:0] flid);
        rep_t ins[$];
        rep_t h, m2;
        bit   was_empty;
        was_empty = (q.size() == 0);
        if (flv) begin
            foreach (q[i]) if (younger(q[i].id, flid)) q[i].v = 1'b0;
        end
        exp_v = 1'b0;
        exp_r = '0;
        if (q.size() > 0) begin
            h = q.pop_front();
            if (h.v) begin
                exp_v = 1'b1;
                exp_r = h;
            end
        end
        if (fp.v && !(flv && younger(fp.id, flid))) ins.push_back(fp);
        m2    = mv;
        m2.fv = 1'b0;
        m2.ff = '0;
        if (mv.v && !(flv && younger(mv.id, flid))) ins.push_back(m2);
`ifdef SCARIV_FPU_DONE_MERGE_BYPASS_EN
        if (was_empty && ins.size() > 0) begin
            exp_v = 1'b1;
            exp_r = ins.pop_front();
        end
`else
        if (was_empty) exp_v = 1'b0;
`endif
        foreach (ins[i]) q.push_back(ins[i]);
        exp_stall = (DEPTH - q.size()) < (2 * SKID);
    endtask

    task automatic step(input rep_t fp, input rep_t mv, input logic flv, input logic [6:0] flid);
        @(negedge clk);
        check();
        last_v     = o_done_valid;
        last_id    = o_done_cmt_id;
        last_fv    = o_done_fflags_valid;
        last_ff    = o_done_fflags;
        last_stall = o_stall;
        if (o_done_valid) seen.push_back(o_done_cmt_id);
        fp_in = fp;
        mv_in = mv;
        fl_v  = flv;
        fl_id = flid;
        model(fp, mv, flv, flid);
    endtask

    task automatic idle(input int n);
        repeat (n) step(IDLE, IDLE, 1'b0, 7'h00);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        lit("rst_valid", 32'(o_done_valid), 0);
        lit("rst_stall", 32'(o_stall), 0);
        lit("rst_cmt", 32'(o_done_cmt_id), 0);
        lit("rst_fflags", 32'({o_done_fflags_valid, o_done_fflags}), 0);
        rst_n = 1'b1;
        idle(2);

        // Single fp report: fixed latency, fflags carried through.
        step(mk(7'h05, 4'h1, 1'b0, 4'h0, 1'b1, 5'h01), IDLE, 1'b0, 7'h00);
        idle(LAT);
        lit("t1_valid", 32'(last_v), 1);
        lit("t1_cmt", 32'(last_id), 32'h05);
        lit("t1_fv", 32'(last_fv), 1);
        lit("t1_ff", 32'(last_ff), 32'h01);
        idle(2);

        // Single mv report: fflags forced to zero.
        step(IDLE, mk(7'h20, 4'h2, 1'b1, 4'h3, 1'b1, 5'h1f), 1'b0, 7'h00);
        idle(LAT);
        lit("mv_valid", 32'(last_v), 1);
        lit("mv_cmt", 32'(last_id), 32'h20);
        lit("mv_fv", 32'(last_fv), 0);
        idle(2);

        // Collision: fp first, then mv.
        seen.delete();
        step(mk(7'h10, 4'h1, 1'b0, 4'h0, 1'b1, 5'h04), mk(7'h11, 4'h2, 1'b0, 4'h0, 1'b0, 5'h00), 1'b0, 7'h00);
        idle(LAT + 2);
        lit("t2_count", 32'(seen.size()), 2);
        lit("t2_first", 32'(seen[0]), 32'h10);
        lit("t2_second", 32'(seen[1]), 32'h11);

        // Two back-to-back collisions: stall rises, nothing dropped.
        seen.delete();
        step(mk(7'h21, 4'h1, 1'b0, 4'h0, 1'b0, 5'h00), mk(7'h22, 4'h2, 1'b0, 4'h0, 1'b0, 5'h00), 1'b0, 7'h00);
        step(mk(7'h23, 4'h4, 1'b0, 4'h0, 1'b1, 5'h02), mk(7'h24, 4'h8, 1'b0, 4'h0, 1'b0, 5'h00), 1'b0, 7'h00);
        lit("t3_stall", 32'(last_stall), 1);
        idle(6);
        lit("t3_count", 32'(seen.size()), 4);
        lit("t3_o0", 32'(seen[0]), 32'h21);
        lit("t3_o3", 32'(seen[3]), 32'h24);

        // Flush behind the branch 0x03.
        seen.delete();
        step(mk(7'h03, 4'h1, 1'b0, 4'h0, 1'b0, 5'h00), mk(7'h04, 4'h2, 1'b0, 4'h0, 1'b0, 5'h00), 1'b0, 7'h00);
        step(mk(7'h05, 4'h4, 1'b0, 4'h0, 1'b0, 5'h00), IDLE, 1'b0, 7'h00);
        step(IDLE, IDLE, 1'b1, 7'h03);
        idle(4);
        lit("t4_first", 32'(seen[0]), 32'h03);
`ifdef SCARIV_FPU_DONE_MERGE_BYPASS_EN
        lit("t4_count", 32'(seen.size()), 2);
`else
        lit("t4_count", 32'(seen.size()), 1);
`endif
        lit("t4_drained", 32'(last_stall), 0);

        // Wrap-bit ordering, flush in the same cycle as the inputs.
        seen.delete();
        step(mk(7'h41, 4'h1, 1'b0, 4'h0, 1'b0, 5'h00), mk(7'h3d, 4'h2, 1'b0, 4'h0, 1'b0, 5'h00), 1'b1, 7'h3e);
        idle(LAT + 2);
        lit("t5a_count", 32'(seen.size()), 1);
        lit("t5a_cmt", 32'(seen[0]), 32'h3d);

        // Wrap-bit ordering, flush after the entries are queued.
        seen.delete();
        step(mk(7'h41, 4'h1, 1'b0, 4'h0, 1'b0, 5'h00), mk(7'h3d, 4'h2, 1'b0, 4'h0, 1'b0, 5'h00), 1'b0, 7'h00);
        step(IDLE, IDLE, 1'b1, 7'h3e);
        idle(4);
`ifdef SCARIV_FPU_DONE_MERGE_BYPASS_EN
        lit("t5b_count", 32'(seen.size()), 2);
`else
        lit("t5b_count", 32'(seen.size()), 1);
        lit("t5b_cmt", 32'(seen[0]), 32'h3d);
`endif

        // Reset with entries queued.
        step(mk(7'h30, 4'h1, 1'b0, 4'h0, 1'b0, 5'h00), mk(7'h31, 4'h2, 1'b0, 4'h0, 1'b0, 5'h00), 1'b0, 7'h00);
        step(mk(7'h32, 4'h1, 1'b0, 4'h0, 1'b0, 5'h00), mk(7'h33, 4'h2, 1'b0, 4'h0, 1'b0, 5'h00), 1'b0, 7'h00);
        @(negedge clk);
        check();
        lit("t6_pre_stall", 32'(o_stall), 1);
        fp_in = IDLE;
        mv_in = IDLE;
        fl_v  = 1'b0;
        rst_n = 1'b0;
        #1;
        lit("t6_rst_valid", 32'(o_done_valid), 0);
        lit("t6_rst_stall", 32'(o_stall), 0);
        lit("t6_rst_cmt", 32'(o_done_cmt_id), 0);
        q.delete();
        exp_v     = 1'b0;
        exp_r     = '0;
        exp_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen.delete();
        idle(10);
        lit("t6_quiet", 32'(seen.size()), 0);

        // Random traffic, bounded by the model's free slots.
        for (int n = 0; n < 3000; n++) begin
            rep_t       f, m;
            int         free;
            logic       flv;
            logic [6:0] flid;
            free = DEPTH - q.size();
            f = {1'b0, 7'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 5'($urandom)};
            m = {1'b0, 7'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 5'($urandom)};
            f.v = ($urandom_range(0, 99) < 45);
            m.v = ($urandom_range(0, 99) < 45);
            if (int'(f.v) + int'(m.v) > free) m.v = 1'b0;
            if (int'(f.v) > free) f.v = 1'b0;
            flv  = ($urandom_range(0, 9) == 0);
            flid = 7'($urandom);
            step(f, m, flv, flid);
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
